// File: rtl/os2ip_octet_assembler.sv
// Big-endian octet stream to DATA_BIT_WIDTH-bit integer (OS2IP) with overflow flag.
// Result is presented on a valid/ready handshake; input is stalled while a result is held.
module os2ip_octet_assembler #(
   parameter int unsigned DATA_BIT_WIDTH = 256,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      s_valid,
   input  logic [7:0]                s_data,
   input  logic                      s_last,
   output logic                      s_ready,
   input  logic                      x_ready,
   output logic [DATA_BIT_WIDTH-1:0] x,
   output logic [CNT_WIDTH-1:0]      x_len,
   output logic                      x_err,
   output logic                      x_valid
);

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_e;

   state_e                    state_q;
   logic [DATA_BIT_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
   logic                      err_q, err_d;
   logic                      s_ready_q;
   logic [DATA_BIT_WIDTH-1:0] x_q;
   logic [CNT_WIDTH-1:0]      x_len_q;
   logic                      x_err_q;
   logic                      x_valid_q;
   logic                      xfer;

   assign xfer = s_valid & s_ready_q;

   // Any nonzero bit in the top octet is lost by this shift, so it marks overflow.
   always_comb begin
      acc_d = {acc_q[DATA_BIT_WIDTH-9:0], s_data};
      err_d = err_q | (acc_q[DATA_BIT_WIDTH-1 -: 8] != '0);
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= COLLECT;
         acc_q     <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         s_ready_q <= 1'b0;
         x_q       <= '0;
         x_len_q   <= '0;
         x_err_q   <= 1'b0;
         x_valid_q <= 1'b0;
      end else if (state_q == COLLECT) begin
         s_ready_q <= 1'b1;
         if (xfer) begin
            if (s_last) begin
               x_q       <= acc_d;
               x_len_q   <= cnt_d;
               x_err_q   <= err_d;
               x_valid_q <= 1'b1;
               acc_q     <= '0;
               cnt_q     <= '0;
               err_q     <= 1'b0;
               s_ready_q <= 1'b0;
               state_q   <= HOLD;
            end else begin
               acc_q <= acc_d;
               cnt_q <= cnt_d;
               err_q <= err_d;
            end
         end
      end else begin
         if (x_ready) begin
            x_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            state_q   <= COLLECT;
         end
      end
   end

   assign s_ready = s_ready_q;
   assign x       = x_q;
   assign x_len   = x_len_q;
   assign x_err   = x_err_q;
   assign x_valid = x_valid_q;

endmodule
